fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode/execute datapath. Owns the PC, reads a
//  synchronous instruction ROM (1-cycle latency), buffers fetched words in a 2-entry queue, and
//  presents the head instruction plus its return address (PC+1) to the datapath. Handles
//  sequential advance, branch/jump/JAL redirect, jump-register redirect and halt, driven by flagPC/flagJR.
// PARAMETERS
//  bits    32  instruction / register word width
//  addr    20  PC width
//  memory  10  ROM index width (ROM holds 2**memory words, indexed by pc[memory-1:0])
//  depth   2   queue entries (fixed at 2; power of two)
// PORTS
//  clock       in   1     single clock, all state updates on posedge
//  reset       in   1     synchronous, active-high
//  flagPC      in   2     00 hold, 01 advance (pop head), 10 redirect, 11 halt
//  flagJR      in   1     with flagPC=10: target = RSvalue[addr-1:0] instead of newAddress
//  newAddress  in   addr  branch/jump/JAL target
//  RSvalue     in   bits  register value for jump-register
//  instruction out  bits  head-of-queue instruction word (0 when queue empty)
//  address     out  addr  head PC + 1 (JAL link value), 0 when queue empty
//  inst_valid  out  1     head entry is valid and not halted
//  halted      out  1     unit in HALT state
// BEHAVIOUR
//  - One clock, reset synchronous active-high. On reset: fetch_pc=0, queue empty (count=0, ptrs=0),
//    inflight=0, state=RUN; outputs instruction=0, address=0, inst_valid=0, halted=0.
//  - States: RUN, HALT. RUN->HALT when flagPC=11 (any cycle). HALT exits only via reset.
//  - Issue: in RUN, ROM read of fetch_pc issued when count + inflight - pop < depth and no redirect
//    this cycle; on issue fetch_pc <= fetch_pc+1 (mod 2**addr), inflight<=1 next cycle.
//  - Response: ROM data valid cycle after issue; written at queue tail with its PC (tag) that cycle
//    unless squashed. inflight cleared when response lands or is squashed.
//  - Pop: flagPC=01 and inst_valid -> head removed. flagPC=01 on empty queue ignored.
//  - Push and pop same cycle allowed; count unchanged. Never push when full (guaranteed by issue rule;
//    assert). Pointers wrap mod depth.
//  - Redirect (flagPC=10): target = flagJR ? RSvalue[addr-1:0] : newAddress. Next cycle: queue flushed,
//    in-flight response squashed (squash flag set, data dropped), fetch_pc=target. Honoured whether or
//    not queue is empty. First instruction at target: issue in cycle R+1, inst_valid high cycle R+3.
//  - Redirect with response arriving same cycle: response discarded.
//  - First instruction after reset release (cycle 0): issue cycle 0, data cycle 1, inst_valid cycle 2.
//  - Steady state with continuous flagPC=01: one instruction per cycle, no bubbles.
//  - HALT: no issue, no push, no pop; queue contents frozen; inst_valid=0; halted=1;
//    instruction/address keep showing head.
//  - fetch_pc wrap from 2**addr-1 to 0; ROM index uses low memory bits only (aliasing intentional).
//  - address = head_pc + 1, addr-bit wrap.
//  - Reset mid-operation: all state cleared same edge; a ROM response in flight is dropped
//    (inflight=0 after reset).
// STRUCTURE
//  - Shared package fetch_pkg: flagPC encodings (PC_HOLD=2'b00, PC_NEXT=2'b01, PC_JUMP=2'b10,
//    PC_HALT=2'b11), state encodings RUN/HALT, depth constant.
//  - One sub-module: inst_rom (sync read, 1-cycle latency, $readmemb init, 2**memory x bits).
//  - Queue storage, pointers, count, PC, inflight/squash and state FSM inline in this module.
// TESTING
//  - Reset then flagPC=01 continuous, ROM[i]=i+100 -> inst_valid rises cycle 2; instruction 100,101,
//    102... one per cycle; address 1,2,3...
//  - flagPC=00 for 5 cycles with queue full -> instruction/address stable, no issue, count=2 held.
//  - At head PC 3 assert flagPC=10, newAddress=40 -> next valid instruction = ROM[40], address 41, old
//    entries and in-flight word never appear.
//  - flagPC=10, flagJR=1, RSvalue=32'h0000_0007 -> instruction=ROM[7], address=8;
//    upper RSvalue bits ignored.
//  - flagPC=11 mid-stream -> halted=1, inst_valid=0 forever; later flagPC=01/10 no effect; reset
//    restores PC 0 fetch.
//  - Assert reset for 1 cycle while response in flight -> stale word not enqueued; ROM[0] appears
//    2 cycles after release.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_queue_unit_pkg;

    localparam int unsigned Bits   = 32;  // instruction / register word width
    localparam int unsigned Addr   = 20;  // PC width
    localparam int unsigned Memory = 10;  // ROM index width
    localparam int unsigned Depth  = 2;   // queue entries, power of two

    typedef logic [Bits-1:0] word_t;
    typedef logic [Addr-1:0] addr_t;

    // flagPC encodings driven by the datapath
    typedef enum logic [1:0] {
        PcHold = 2'b00,
        PcNext = 2'b01,
        PcJump = 2'b10,
        PcHalt = 2'b11
    } flag_pc_e;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    // Program image held in the ROM: word i contains i + 100.
    function automatic word_t rom_image_word(input logic [Memory-1:0] idx);
        return word_t'(idx) + word_t'(100);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch <-> datapath handshake: control flags in, head instruction out.
interface fetch_queue_unit_if;
    import fetch_queue_unit_pkg::*;

    logic [1:0] flag_pc;
    logic       flag_jr;
    addr_t      new_address;
    word_t      rs_value;
    word_t      instruction;
    addr_t      address;
    logic       inst_valid;
    logic       halted;

    // Datapath side
    modport master (
        output flag_pc, flag_jr, new_address, rs_value,
        input  instruction, address, inst_valid, halted
    );

    // Fetch unit side
    modport slave (
        input  flag_pc, flag_jr, new_address, rs_value,
        output instruction, address, inst_valid, halted
    );

endinterface

// File: rtl/fetch_queue_unit_inst_rom.sv
// Synchronous-read instruction ROM, one cycle from index to data.
module fetch_queue_unit_inst_rom
    import fetch_queue_unit_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_en,
    input  logic [Memory-1:0] i_index,
    output word_t             o_data
);

    word_t r_data;

    // Registered read; data only meaningful the cycle after an enabled read
    always_ff @(posedge i_clock) begin
        if (i_en) begin
            r_data <= rom_image_word(i_index);
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, reads the ROM and buffers words in a
// 2-entry queue whose head (plus its link address) is presented to the datapath.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    fetch_queue_unit_if.slave bus
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    state_e          r_state;
    state_e          w_state_d;
    addr_t           r_fetch_pc;
    addr_t           r_resp_pc;     // PC tag of the word returning from the ROM
    logic            r_inflight;
    logic [CntW-1:0] r_count;
    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    word_t           r_q_inst [Depth];
    addr_t           r_q_pc   [Depth];

    logic            w_run;
    logic            w_redirect;
    logic            w_halt_req;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CntW:0]   w_occupancy;
    addr_t           w_target;
    word_t           w_rom_data;

    fetch_queue_unit_inst_rom u_rom (
        .i_clock (i_clock),
        .i_en    (w_issue),
        .i_index (r_fetch_pc[Memory-1:0]),
        .o_data  (w_rom_data)
    );

    // Decode the datapath request into issue / push / pop / redirect strobes
    always_comb begin
        w_run       = (r_state == StRun);
        w_redirect  = w_run && (bus.flag_pc == PcJump);
        w_halt_req  = w_run && (bus.flag_pc == PcHalt);
        w_valid     = w_run && (r_count != '0);
        w_pop       = w_valid && (bus.flag_pc == PcNext);
        // A response landing in a redirect cycle belongs to the old path
        w_push      = w_run && r_inflight && !w_redirect;
        // Entries held or promised after this cycle's pop
        w_occupancy = {1'b0, r_count} + (CntW+1)'(r_inflight) - (CntW+1)'(w_pop);
        w_issue     = w_run && !w_redirect && (w_occupancy < (CntW+1)'(Depth));
        w_target    = bus.flag_jr ? bus.rs_value[Addr-1:0] : bus.new_address;
    end

    // Next state: HALT is sticky until reset
    always_comb begin
        w_state_d = r_state;
        if (w_halt_req) begin
            w_state_d = StHalt;
        end
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // PC, in-flight tracking; a redirect overrides sequential advance
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fetch_pc <= '0;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
        end else begin
            // Single-cycle ROM: whatever is in flight lands or is dropped next cycle
            r_inflight <= w_issue;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + addr_t'(1);
                r_resp_pc  <= r_fetch_pc;
            end
        end
    end

    // Queue pointers and occupancy; redirect flushes
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (w_redirect) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PtrW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    // Queue storage; contents are only observed through r_count, so no reset
    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_q_inst[r_tail] <= w_rom_data;
            r_q_pc[r_tail]   <= r_resp_pc;
        end
    end

    // The issue rule must leave room for every response
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_push) begin
            assert (r_count < CntW'(Depth));
        end
    end

    // Head presentation; held while halted
    always_comb begin
        bus.instruction = '0;
        bus.address     = '0;
        if (r_count != '0) begin
            bus.instruction = r_q_inst[r_head];
            bus.address     = r_q_pc[r_head] + addr_t'(1);
        end
        bus.inst_valid = w_valid;
        bus.halted     = (r_state == StHalt);
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; ROM word i holds i + 100.
module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fetch_queue_unit_if u_if ();

    fetch_queue_unit dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic vld, input logic [31:0] inst,
                               input logic [31:0] addr);
        check_eq({tag, "_valid"}, 32'(u_if.inst_valid), 32'(vld));
        check_eq({tag, "_inst"}, u_if.instruction, inst);
        check_eq({tag, "_addr"}, 32'(u_if.address), addr);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        u_if.flag_pc     = 2'b00;
        u_if.flag_jr     = 1'b0;
        u_if.new_address = '0;
        u_if.rs_value    = '0;
        repeat (3) step();

        // Reset state
        expect_head("reset", 1'b0, 0, 0);
        check_eq("reset_halted", 32'(u_if.halted), 0);
        check_eq("reset_count", 32'(dut.r_count), 0);
        check_eq("reset_pc", 32'(dut.r_fetch_pc), 0);

        // Continuous advance from reset: first valid in cycle 2
        rst = 1'b0;
        u_if.flag_pc = 2'b01;
        check_eq("c0_valid", 32'(u_if.inst_valid), 0);
        step();
        check_eq("c1_valid", 32'(u_if.inst_valid), 0);
        step();
        for (int k = 0; k < 4; k++) begin
            expect_head("stream", 1'b1, 32'(100 + k), 32'(1 + k));
            step();
        end

        // Hold: queue fills to 2 and stays frozen, no further issue
        u_if.flag_pc = 2'b00;
        expect_head("hold_first", 1'b1, 104, 5);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            expect_head("hold", 1'b1, 104, 5);
            check_eq("hold_count", 32'(dut.r_count), 2);
            check_eq("hold_pc", 32'(dut.r_fetch_pc), 6);
            step();
        end

        // Resume streaming from a full queue
        u_if.flag_pc = 2'b01;
        for (int k = 0; k < 4; k++) begin
            expect_head("resume", 1'b1, 32'(104 + k), 32'(5 + k));
            step();
        end

        // Redirect to 40 with head 108 and 109 in flight
        expect_head("pre_jump", 1'b1, 108, 9);
        u_if.flag_pc     = 2'b10;
        u_if.new_address = 20'd40;
        step();
        u_if.flag_pc = 2'b01;  // pop on an empty queue must be ignored
        check_eq("jump_r1_valid", 32'(u_if.inst_valid), 0);
        check_eq("jump_r1_count", 32'(dut.r_count), 0);
        check_eq("jump_r1_pc", 32'(dut.r_fetch_pc), 40);
        step();
        check_eq("jump_r2_valid", 32'(u_if.inst_valid), 0);
        check_eq("jump_r2_count", 32'(dut.r_count), 0);
        step();
        expect_head("jump_r3", 1'b1, 140, 41);
        step();
        expect_head("jump_r4", 1'b1, 141, 42);

        // Jump-register: only RSvalue[19:0] forms the target
        u_if.flag_pc  = 2'b10;
        u_if.flag_jr  = 1'b1;
        u_if.rs_value = 32'hFFF0_0007;
        step();
        u_if.flag_pc = 2'b01;
        u_if.flag_jr = 1'b0;
        check_eq("jr_r1_valid", 32'(u_if.inst_valid), 0);
        step();
        step();
        expect_head("jr_r3", 1'b1, 107, 8);
        step();
        expect_head("jr_r4", 1'b1, 108, 9);

        // Redirect to the top of the PC range: address and fetch PC wrap
        u_if.flag_pc     = 2'b10;
        u_if.new_address = 20'hFFFFF;
        step();
        u_if.flag_pc = 2'b01;
        step();
        step();
        expect_head("wrap_top", 1'b1, 1123, 0);
        step();
        expect_head("wrap_zero", 1'b1, 100, 1);
        step();
        expect_head("wrap_one", 1'b1, 101, 2);

        // Halt mid-stream; later requests have no effect
        u_if.flag_pc = 2'b11;
        step();
        for (int k = 0; k < 5; k++) begin
            u_if.flag_pc     = (k < 3) ? 2'b01 : 2'b10;
            u_if.new_address = 20'd40;
            check_eq("halt_halted", 32'(u_if.halted), 1);
            expect_head("halt", 1'b0, 101, 2);
            check_eq("halt_count", 32'(dut.r_count), 2);
            check_eq("halt_pc", 32'(dut.r_fetch_pc), 3);
            step();
        end

        // Reset leaves HALT and restarts at PC 0
        rst = 1'b1;
        u_if.flag_pc = 2'b01;
        step();
        rst = 1'b0;
        check_eq("rst1_halted", 32'(u_if.halted), 0);
        check_eq("rst1_c0_valid", 32'(u_if.inst_valid), 0);
        step();
        step();
        expect_head("rst1_c2", 1'b1, 100, 1);
        step();
        expect_head("rst1_c3", 1'b1, 101, 2);

        // One-cycle reset with a ROM read in flight: stale word is dropped
        check_eq("pre_rst_inflight", 32'(dut.r_inflight), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst2_c0_valid", 32'(u_if.inst_valid), 0);
        check_eq("rst2_c0_count", 32'(dut.r_count), 0);
        check_eq("rst2_c0_inflight", 32'(dut.r_inflight), 0);
        step();
        check_eq("rst2_c1_valid", 32'(u_if.inst_valid), 0);
        step();
        expect_head("rst2_c2", 1'b1, 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
